// File: rtl/m_7seg_scan_driver.sv
`default_nettype none
// ============================================================================
// Module   : m_7seg_scan_driver
// Purpose  : Multiplexed N-digit hex 7-segment display driver. Holds N hex
//            digits plus decimal points in a double-buffered register pair,
//            scans them onto one shared segment bus with a one-hot digit
//            enable, and supports leading-zero suppression and selectable
//            pin polarity.
// Ports    : I_CLK       system clock, rising edge
//            I_RST       synchronous reset, active-high
//            I_EN        scan enable; low blanks the display, freezes scan
//            I_LOAD      single-cycle strobe capturing data into the shadow
//            I_DATA      4*N_DIGITS hex nibbles, [3:0] = digit 0
//            I_DP        per-digit decimal point
//            I_BLANK_LZ  leading-zero suppression enable
//            O_SEG       segments, bit0 = A .. bit6 = G
//            O_DP        decimal point of the selected digit
//            O_DIG       one-hot digit enable
//            O_FRAME     one-cycle pulse after each frame wrap
//            O_PENDING   shadow holds data not yet applied
// Revision : 1.0 - initial release
// ============================================================================
module m_7seg_scan_driver #(
  parameter int N_DIGITS       = 4,
  parameter int PRESCALE       = 50000,
  parameter bit SEG_ACTIVE_LOW = 1'b0,
  parameter bit DIG_ACTIVE_LOW = 1'b1
) (
  input  logic                    I_CLK,
  input  logic                    I_RST,
  input  logic                    I_EN,
  input  logic                    I_LOAD,
  input  logic [4*N_DIGITS-1:0]   I_DATA,
  input  logic [N_DIGITS-1:0]     I_DP,
  input  logic                    I_BLANK_LZ,
  output logic [6:0]              O_SEG,
  output logic                    O_DP,
  output logic [N_DIGITS-1:0]     O_DIG,
  output logic                    O_FRAME,
  output logic                    O_PENDING
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam logic [PW-1:0] C_PRESC_LAST = PW'(PRESCALE - 1);
  localparam logic [IW-1:0] C_IDX_LAST   = IW'(N_DIGITS - 1);

  // Scan state
  logic [PW-1:0]           presc_q;
  logic [IW-1:0]           idx_q;
  logic                    frame_q;

  // Active (displayed) and shadow (pending) copies
  logic [4*N_DIGITS-1:0]   act_data_q, shd_data_q;
  logic [N_DIGITS-1:0]     act_dp_q,   shd_dp_q;
  logic                    act_lz_q,   shd_lz_q;
  logic                    pend_q;

  // Registered logical (polarity-free) outputs
  logic [6:0]              seg_q;
  logic                    dp_q;
  logic [N_DIGITS-1:0]     dig_q;

  // Next-state / combinational values
  logic                    tick_d;
  logic                    wrap_d;
  logic [3:0]              nib_d;
  logic                    dp_sel_d;
  logic                    blank_d;
  logic                    lz_run_d;
  logic [6:0]              seg_d;
  logic                    dp_d;
  logic [N_DIGITS-1:0]     dig_d;

  function automatic logic [6:0] f_glyph(input logic [3:0] nib);
    logic [6:0] g;
    case (nib)
      4'h0: g = 7'h3F;
      4'h1: g = 7'h06;
      4'h2: g = 7'h5B;
      4'h3: g = 7'h4F;
      4'h4: g = 7'h66;
      4'h5: g = 7'h6D;
      4'h6: g = 7'h7D;
      4'h7: g = 7'h07;
      4'h8: g = 7'h7F;
      4'h9: g = 7'h6F;
      4'hA: g = 7'h77;
      4'hB: g = 7'h7C;
      4'hC: g = 7'h39;
      4'hD: g = 7'h5E;
      4'hE: g = 7'h79;
      default: g = 7'h71;
    endcase
    return g;
  endfunction

  assign tick_d = I_EN && (presc_q == C_PRESC_LAST);
  // The tick that wraps the digit index marks the frame boundary.
  assign wrap_d = tick_d && (idx_q == C_IDX_LAST);

  always_comb begin
    nib_d    = 4'h0;
    dp_sel_d = 1'b0;
    blank_d  = 1'b0;
    dig_d    = '0;
    // Walk from the most significant digit down; lz_run_d stays high while
    // every nibble seen so far (including the current one) is zero.
    lz_run_d = act_lz_q;
    for (int i = N_DIGITS - 1; i >= 0; i--) begin
      lz_run_d = lz_run_d && (act_data_q[4*i +: 4] == 4'h0);
      if (idx_q == IW'(i)) begin
        nib_d    = act_data_q[4*i +: 4];
        dp_sel_d = act_dp_q[i];
        dig_d[i] = 1'b1;
        blank_d  = lz_run_d && (i != 0);
      end
    end
    seg_d = (I_EN && !blank_d) ? f_glyph(nib_d) : 7'h00;
    dp_d  = I_EN && dp_sel_d;
    if (!I_EN) begin
      dig_d = '0;
    end
  end

  always_ff @(posedge I_CLK) begin
    if (I_RST) begin
      presc_q    <= '0;
      idx_q      <= '0;
      frame_q    <= 1'b0;
      act_data_q <= '0;
      act_dp_q   <= '0;
      act_lz_q   <= 1'b0;
      shd_data_q <= '0;
      shd_dp_q   <= '0;
      shd_lz_q   <= 1'b0;
      pend_q     <= 1'b0;
      seg_q      <= 7'h00;
      dp_q       <= 1'b0;
      dig_q      <= '0;
    end else begin
      if (tick_d) begin
        presc_q <= '0;
        idx_q   <= (idx_q == C_IDX_LAST) ? '0 : idx_q + 1'b1;
      end else if (I_EN) begin
        presc_q <= presc_q + 1'b1;
      end

      frame_q <= wrap_d;

      if (I_LOAD) begin
        shd_data_q <= I_DATA;
        shd_dp_q   <= I_DP;
        shd_lz_q   <= I_BLANK_LZ;
      end

      // A load coinciding with the boundary bypasses the shadow so the new
      // value is shown from the very next frame.
      if (wrap_d && I_LOAD) begin
        act_data_q <= I_DATA;
        act_dp_q   <= I_DP;
        act_lz_q   <= I_BLANK_LZ;
        pend_q     <= 1'b0;
      end else if (wrap_d && pend_q) begin
        act_data_q <= shd_data_q;
        act_dp_q   <= shd_dp_q;
        act_lz_q   <= shd_lz_q;
        pend_q     <= 1'b0;
      end else if (I_LOAD) begin
        pend_q     <= 1'b1;
      end

      seg_q <= seg_d;
      dp_q  <= dp_d;
      dig_q <= dig_d;
    end
  end

  // Logical 0 is "inactive", so the reset value lands on the inactive pin level.
  assign O_SEG     = seg_q ^ {7{SEG_ACTIVE_LOW}};
  assign O_DP      = dp_q ^ SEG_ACTIVE_LOW;
  assign O_DIG     = dig_q ^ {N_DIGITS{DIG_ACTIVE_LOW}};
  assign O_FRAME   = frame_q;
  assign O_PENDING = pend_q;

endmodule
`default_nettype wire

// File: tb/tb_m_7seg_scan_driver.sv
`default_nettype none
// ============================================================================
// Module   : tb_m_7seg_scan_driver
// Purpose  : Self-checking bench for m_7seg_scan_driver (4 digits, prescale 4,
//            default polarity) using a counting reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_m_7seg_scan_driver;

  localparam int ND = 4;
  localparam int PS = 4;

  logic        clk;
  logic        rst;
  logic        en;
  logic        load;
  logic [15:0] data;
  logic [3:0]  dp;
  logic        blz;
  logic [6:0]  o_seg;
  logic        o_dp;
  logic [3:0]  o_dig;
  logic        o_frame;
  logic        o_pend;

  m_7seg_scan_driver #(
    .N_DIGITS(ND), .PRESCALE(PS), .SEG_ACTIVE_LOW(1'b0), .DIG_ACTIVE_LOW(1'b1)
  ) dut (
    .I_CLK(clk), .I_RST(rst), .I_EN(en), .I_LOAD(load), .I_DATA(data),
    .I_DP(dp), .I_BLANK_LZ(blz), .O_SEG(o_seg), .O_DP(o_dp), .O_DIG(o_dig),
    .O_FRAME(o_frame), .O_PENDING(o_pend)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  logic [6:0] glyph [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                             7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  // Reference model: enabled-cycle count within the frame decides the digit.
  int          ecnt;
  logic [15:0] m_act, m_shd;
  logic [3:0]  m_adp, m_sdp;
  logic        m_alz, m_slz, m_pend;
  logic [13:0] exp_vec;
  wire  [13:0] dut_vec = {o_seg, o_dp, o_dig, o_frame, o_pend};

  task automatic model_step();
    int d;
    logic bnd, e_dp;
    logic [6:0] s;
    logic [3:0] dl;
    if (rst) begin
      ecnt = 0; m_act = 0; m_shd = 0; m_adp = 0; m_sdp = 0;
      m_alz = 0; m_slz = 0; m_pend = 0;
      exp_vec = {7'h00, 1'b0, 4'hF, 1'b0, 1'b0};
      return;
    end
    d    = (ecnt / PS) % ND;
    bnd  = en && (((ecnt + 1) % (PS * ND)) == 0);
    s    = 7'h00; e_dp = 1'b0; dl = 4'b0000;
    if (en) begin
      s = glyph[(m_act >> (4 * d)) & 16'hF];
      if (m_alz && d != 0 && (m_act >> (4 * d)) == 16'h0) s = 7'h00;
      e_dp = m_adp[d];
      dl   = 4'b0001 << d;
    end
    if (load) begin
      m_shd = data; m_sdp = dp; m_slz = blz;
    end
    if (bnd && load) begin
      m_act = data; m_adp = dp; m_alz = blz; m_pend = 1'b0;
    end else if (bnd && m_pend) begin
      m_act = m_shd; m_adp = m_sdp; m_alz = m_slz; m_pend = 1'b0;
    end else if (load) begin
      m_pend = 1'b1;
    end
    if (en) ecnt = (ecnt + 1) % (PS * ND);
    exp_vec = {s, e_dp, ~dl, bnd, m_pend};
  endtask

  // One clock: model follows the same edge, then we land on the falling edge.
  task automatic cyc();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  // Advance until O_FRAME is seen, checking against the model on the way.
  task automatic wait_frame();
    bit seen = 0;
    for (int k = 0; k < 40 && !seen; k++) begin
      cyc();
      n_checks++;
      if (dut_vec !== exp_vec) $display("FAIL wait_frame_model got=%h want=%h", dut_vec, exp_vec);
      else n_pass++;
      seen = o_frame;
    end
    n_checks++;
    if (!seen) $display("FAIL wait_frame_timeout got=no_frame want=frame");
    else n_pass++;
  endtask

  task automatic test_reset();
    rst = 1; cyc(); cyc();
    n_checks++;
    if (dut_vec !== 14'b0000000_0_1111_0_0) $display("FAIL reset_outputs got=%h want=%h", dut_vec, 14'b0000000_0_1111_0_0);
    else n_pass++;
    n_checks++;
    if (dut_vec !== exp_vec) $display("FAIL reset_model got=%h want=%h", dut_vec, exp_vec);
    else n_pass++;
    rst = 0;
  endtask

  task automatic test_scan();
    logic [6:0] tbl [4] = '{7'h66, 7'h4F, 7'h5B, 7'h06};
    logic [3:0] dsel;
    en = 1; data = 16'h1234; dp = 4'h0; blz = 0; load = 1; cyc(); load = 0;
    wait_frame();
    for (int k = 0; k < 16; k++) begin
      cyc();
      dsel = 4'b0001 << (k / 4);
      n_checks++;
      if (o_dig !== ~dsel || o_seg !== tbl[k/4] || o_frame !== (k == 15))
        $display("FAIL scan_slot%0d got dig=%b seg=%h frm=%b want dig=%b seg=%h frm=%b",
                 k, o_dig, o_seg, o_frame, ~dsel, tbl[k/4], (k == 15));
      else n_pass++;
      n_checks++;
      if (dut_vec !== exp_vec) $display("FAIL scan_model got=%h want=%h", dut_vec, exp_vec);
      else n_pass++;
    end
  endtask

  task automatic test_lz();
    logic [15:0] vals [3] = '{16'h0030, 16'h0000, 16'h0000};
    logic        lzs  [3] = '{1'b1, 1'b1, 1'b0};
    logic [6:0]  want [3][4] = '{'{7'h3F, 7'h4F, 7'h00, 7'h00},
                                 '{7'h3F, 7'h00, 7'h00, 7'h00},
                                 '{7'h3F, 7'h3F, 7'h3F, 7'h3F}};
    for (int c = 0; c < 3; c++) begin
      data = vals[c]; blz = lzs[c]; load = 1; cyc(); load = 0;
      wait_frame();
      for (int k = 0; k < 16; k++) begin
        cyc();
        n_checks++;
        if (o_seg !== want[c][k/4] || dut_vec !== exp_vec)
          $display("FAIL lz_case%0d_slot%0d got seg=%h vec=%h want seg=%h vec=%h",
                   c, k, o_seg, dut_vec, want[c][k/4], exp_vec);
        else n_pass++;
      end
    end
  endtask

  task automatic test_pending();
    wait_frame();
    for (int k = 0; k < 5; k++) cyc();
    data = 16'h5678; blz = 0; load = 1; cyc(); load = 0;
    n_checks++;
    if (o_pend !== 1'b1 || o_dig !== 4'b1101) $display("FAIL pend_set got pend=%b dig=%b want pend=1 dig=1101", o_pend, o_dig);
    else n_pass++;
    for (int k = 0; k < 10; k++) begin
      cyc();
      n_checks++;
      if (dut_vec !== exp_vec || (k < 9 && (o_seg !== 7'h3F || o_pend !== 1'b1)))
        $display("FAIL pend_old_frame got=%h want=%h", dut_vec, exp_vec);
      else n_pass++;
    end
    n_checks++;
    if (o_frame !== 1'b1 || o_pend !== 1'b0) $display("FAIL pend_swap got frm=%b pend=%b want frm=1 pend=0", o_frame, o_pend);
    else n_pass++;
    cyc();
    n_checks++;
    if (o_seg !== 7'h7F || o_dig !== 4'b1110 || o_pend !== 1'b0)
      $display("FAIL pend_new got seg=%h dig=%b pend=%b want seg=7f dig=1110 pend=0", o_seg, o_dig, o_pend);
    else n_pass++;
  endtask

  task automatic test_load_on_wrap();
    logic [6:0] tbl [4] = '{7'h5E, 7'h39, 7'h7C, 7'h77};
    wait_frame();
    for (int k = 0; k < 15; k++) cyc();
    data = 16'hABCD; load = 1; cyc(); load = 0;
    n_checks++;
    if (o_frame !== 1'b1 || o_pend !== 1'b0) $display("FAIL wrap_load got frm=%b pend=%b want frm=1 pend=0", o_frame, o_pend);
    else n_pass++;
    for (int k = 0; k < 16; k++) begin
      cyc();
      n_checks++;
      if (o_seg !== tbl[k/4] || o_pend !== 1'b0 || dut_vec !== exp_vec)
        $display("FAIL wrap_frame_slot%0d got seg=%h pend=%b want seg=%h pend=0", k, o_seg, o_pend, tbl[k/4]);
      else n_pass++;
    end
  endtask

  task automatic test_en_hold();
    logic [3:0] dig_before;
    wait_frame();
    cyc(); cyc();
    dig_before = o_dig;
    en = 0;
    for (int k = 0; k < 10; k++) begin
      cyc();
      n_checks++;
      if (o_dig !== 4'b1111 || o_seg !== 7'h00 || o_frame !== 1'b0 || dut_vec !== exp_vec)
        $display("FAIL hold_%0d got dig=%b seg=%h frm=%b want dig=1111 seg=00 frm=0", k, o_dig, o_seg, o_frame);
      else n_pass++;
    end
    en = 1;
    for (int k = 0; k < 14; k++) begin
      cyc();
      n_checks++;
      if (o_frame !== (k == 13) || dut_vec !== exp_vec || (k == 0 && o_dig !== dig_before))
        $display("FAIL resume_%0d got=%h want=%h", k, dut_vec, exp_vec);
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid();
    wait_frame();
    for (int k = 0; k < 9; k++) cyc();
    data = 16'h9999; blz = 1; load = 1; cyc(); load = 0;
    n_checks++;
    if (o_dig !== 4'b1011 || o_pend !== 1'b1) $display("FAIL rstmid_pre got dig=%b pend=%b want dig=1011 pend=1", o_dig, o_pend);
    else n_pass++;
    rst = 1; cyc(); rst = 0;
    n_checks++;
    if (dut_vec !== 14'b0000000_0_1111_0_0) $display("FAIL rstmid_outputs got=%h want=%h", dut_vec, 14'b0000000_0_1111_0_0);
    else n_pass++;
    cyc();
    n_checks++;
    if (o_seg !== 7'h3F || o_dig !== 4'b1110 || o_pend !== 1'b0)
      $display("FAIL rstmid_after got seg=%h dig=%b pend=%b want seg=3f dig=1110 pend=0", o_seg, o_dig, o_pend);
    else n_pass++;
  endtask

  task automatic test_random();
    for (int k = 0; k < 600; k++) begin
      rst  = ($urandom_range(0, 99) < 2);
      en   = ($urandom_range(0, 9) != 0);
      load = ($urandom_range(0, 5) == 0);
      data = 16'($urandom);
      if ($urandom_range(0, 2) == 0) data = data & 16'h00FF;
      dp   = 4'($urandom);
      blz  = 1'($urandom);
      cyc();
      n_checks++;
      if (dut_vec !== exp_vec) $display("FAIL random_%0d got=%h want=%h", k, dut_vec, exp_vec);
      else n_pass++;
    end
    rst = 0; load = 0; en = 1;
  endtask

  initial begin
    rst = 1; en = 0; load = 0; data = 16'h0; dp = 4'h0; blz = 0;
    ecnt = 0; m_act = 0; m_shd = 0; m_adp = 0; m_sdp = 0;
    m_alz = 0; m_slz = 0; m_pend = 0; exp_vec = 14'h0;
    @(negedge clk);
    test_reset();
    test_scan();
    test_lz();
    test_pending();
    test_load_on_wrap();
    test_en_hold();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
